// File: rtl/data_sram_if.sv
// Data-side SRAM bus between the EX/MEM requester and the on-chip data memory.
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_mem;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  stallreq_for_mem
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output stallreq_for_mem
  );
endinterface

// File: rtl/data_sram_slave.sv
// Word-addressed data SRAM with byte-lane writes, read-before-write data and
// an optional fixed number of wait states signalled through stallreq_for_mem.
module data_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic      clk,
  input  logic      rst,
  data_sram_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [3:0]              cnt_r;
  logic [3:0]              cnt_nxt_s;
  logic                    stall_s;
  logic                    complete_s;
  logic [31:0]             rdata_r;
  logic [ADDR_WIDTH-1:0]   idx_s;
  logic                    addr_unused_s;
  logic [31:0]             mem_r [0:(1 << ADDR_WIDTH) - 1];

  // Upper and lane-offset address bits alias / are selected via wen.
  assign idx_s         = bus.data_sram_addr[ADDR_WIDTH+1:2];
  assign addr_unused_s = ^{bus.data_sram_addr[31:ADDR_WIDTH+2], bus.data_sram_addr[1:0]};

  // Wait-state sequencing: stall decision and completion strobe.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.data_sram_en) begin
          if (WAIT_CYCLES == 0) begin
            complete_s = 1'b1;
          end else begin
            stall_s     = 1'b1;
            state_nxt_s = BUSY;
            cnt_nxt_s   = CNT_LOAD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (!bus.data_sram_en) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r != 4'd0) begin
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          complete_s  = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Read port: returns the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 32'h0000_0000;
    end else if (complete_s) begin
      rdata_r <= mem_r[idx_s];
    end
  end

  // Byte-lane write port; reset cancels a completing write.
  always_ff @(posedge clk) begin
    if (!rst && complete_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i]) begin
          mem_r[idx_s][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.data_sram_rdata  = rdata_r;
  assign bus.stallreq_for_mem = stall_s;

endmodule

// File: tb/tb_data_sram_slave.sv
// Self-checking bench: a zero-wait and a three-wait instance driven by directed
// tables, hand sequences and random traffic against a word-array model.
module tb_data_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst3;
  data_sram_if bus0();
  data_sram_if bus3();

  data_sram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0.slave));
  data_sram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m0 [1024];
  bit          k0 [1024];
  logic [31:0] exp0;
  bit          exp0_k;
  logic [31:0] m3 [1024];
  bit          k3 [1024];
  logic [31:0] exp3;
  bit          exp3_k;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_exp;
    logic        chk;
  } vec_t;

  vec_t tbl [15];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wen,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One cycle on the zero-wait instance; stall must never rise.
  task automatic cyc0(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int i;
    bus0.data_sram_en    = en;
    bus0.data_sram_wen   = wen;
    bus0.data_sram_addr  = addr;
    bus0.data_sram_wdata = wdata;
    @(negedge clk);
    check1("stall0", bus0.stallreq_for_mem, 1'b0);
    @(posedge clk);
    if (en) begin
      i      = widx(addr);
      exp0   = m0[i];
      exp0_k = k0[i];
      m0[i]  = merge(m0[i], wen, wdata);
      k0[i]  = k0[i] || (wen == 4'hF);
    end
    #1;
    if (exp0_k) check32("rdata0", bus0.data_sram_rdata, exp0);
  endtask

  // One complete access on the three-wait instance: stall 1,1,1,0 then data.
  task automatic acc3(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    int i;
    bus3.data_sram_en    = 1'b1;
    bus3.data_sram_wen   = wen;
    bus3.data_sram_addr  = addr;
    bus3.data_sram_wdata = wdata;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check1($sformatf("stall3_c%0d", k), bus3.stallreq_for_mem, (k < 3) ? 1'b1 : 1'b0);
      @(posedge clk);
      if (k == 3) begin
        i      = widx(addr);
        exp3   = m3[i];
        exp3_k = k3[i];
        m3[i]  = merge(m3[i], wen, wdata);
        k3[i]  = k3[i] || (wen == 4'hF);
      end
      #1;
      if (exp3_k) check32($sformatf("rdata3_c%0d", k), bus3.data_sram_rdata, exp3);
    end
  endtask

  task automatic idle3(input int n);
    bus3.data_sram_en = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check1("stall3_idle", bus3.stallreq_for_mem, 1'b0);
      @(posedge clk);
      #1;
      if (exp3_k) check32("rdata3_idle", bus3.data_sram_rdata, exp3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    tbl = '{
      '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1},
      '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
      '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1},
      '{1'b1, 4'h0, 32'h0000_0013, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1},
      '{1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 32'hDEAD_BEEF, 1'b1},
      '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAA_BEEF, 1'b1},
      '{1'b1, 4'hF, 32'h0000_1004, 32'h1234_5678, 32'h0000_0000, 1'b0},
      '{1'b1, 4'h0, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678, 1'b1},
      '{1'b0, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1},
      '{1'b1, 4'hF, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 1'b0},
      '{1'b1, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'hCAFE_F00D, 1'b1}
    };

    for (int i = 0; i < 1024; i++) begin
      k0[i] = 1'b0;
      k3[i] = 1'b0;
    end
    rst0 = 1'b1;
    rst3 = 1'b1;
    bus0.data_sram_en = 1'b0; bus0.data_sram_wen = 4'h0;
    bus0.data_sram_addr = 32'h0; bus0.data_sram_wdata = 32'h0;
    bus3.data_sram_en = 1'b0; bus3.data_sram_wen = 4'h0;
    bus3.data_sram_addr = 32'h0; bus3.data_sram_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst3 = 1'b0;
    exp0 = 32'h0; exp0_k = 1'b1;
    exp3 = 32'h0; exp3_k = 1'b1;
    check32("reset_rdata0", bus0.data_sram_rdata, 32'h0);
    check32("reset_rdata3", bus3.data_sram_rdata, 32'h0);

    // Directed table on the zero-wait instance.
    for (int r = 0; r < 15; r++) begin
      cyc0(tbl[r].en, tbl[r].wen, tbl[r].addr, tbl[r].wdata);
      if (tbl[r].chk) check32($sformatf("tbl_row%0d", r), bus0.data_sram_rdata, tbl[r].rdata_exp);
    end

    // Random back-to-back traffic over a small aliased window.
    for (int i = 0; i < 16; i++) cyc0(1'b1, 4'hF, 32'(i) << 2, $urandom());
    for (int n = 0; n < 300; n++) begin
      a = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
      cyc0(($urandom_range(0, 3) != 0), w, a, $urandom());
    end

    // Three-wait instance: idle, seed, back-to-back reads.
    idle3(5);
    acc3(4'hF, 32'h0000_0020, 32'h5A5A_1234);
    acc3(4'h0, 32'h0000_0020, 32'h0);
    check32("w3_read", bus3.data_sram_rdata, 32'h5A5A_1234);
    acc3(4'h0, 32'h0000_0023, 32'h0);

    // Abort: request dropped in the second stall cycle.
    bus3.data_sram_en = 1'b1; bus3.data_sram_wen = 4'hF;
    bus3.data_sram_addr = 32'h0000_0020; bus3.data_sram_wdata = 32'hFFFF_FFFF;
    @(negedge clk); check1("abort_stall1", bus3.stallreq_for_mem, 1'b1);
    @(posedge clk); #1;
    bus3.data_sram_en = 1'b0;
    @(negedge clk); check1("abort_stall2", bus3.stallreq_for_mem, 1'b0);
    @(posedge clk); #1;
    check32("abort_hold", bus3.data_sram_rdata, exp3);
    idle3(1);
    acc3(4'h0, 32'h0000_0020, 32'h0);
    check32("abort_nowrite", bus3.data_sram_rdata, 32'h5A5A_1234);

    // Reset in the second cycle of a pending write.
    bus3.data_sram_en = 1'b1; bus3.data_sram_wen = 4'hF;
    bus3.data_sram_addr = 32'h0000_0020; bus3.data_sram_wdata = 32'hFFFF_FFFF;
    @(negedge clk); check1("rst_stall1", bus3.stallreq_for_mem, 1'b1);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    bus3.data_sram_en = 1'b0;
    exp3 = 32'h0; exp3_k = 1'b1;
    check32("rst_rdata", bus3.data_sram_rdata, 32'h0);
    idle3(2);
    acc3(4'h0, 32'h0000_0020, 32'h0);
    check32("rst_nowrite", bus3.data_sram_rdata, 32'h5A5A_1234);

    // Random transactions with random idle gaps on the three-wait instance.
    for (int i = 0; i < 8; i++) if (i != 8) acc3(4'hF, 32'(i) << 2, $urandom());
    for (int n = 0; n < 40; n++) begin
      a = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
      acc3(w, a, $urandom());
      idle3($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
